// File: rtl/sb_tx_serializer_pkt.sv
// sb_tx_serializer_pkt: FIFO-buffered sideband serializer with post-packet dead time and clock-gate enable
// Ports: pll_clk/rst = bit clock and synchronous active-high reset;
//        data_in/data_valid/data_ready = packet push handshake (ready = FIFO not full);
//        enable = permits starting a new packet; TXDATASB/TXCKSB_en = serial bit and clock-gate enable;
//        busy = transmitting or in dead time; fifo_level = packets currently queued.
module sb_tx_serializer_pkt #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 4,
    parameter int GAP_CYCLES = 32,
    parameter bit MSB_FIRST  = 1'b0
) (
    input  logic                            pll_clk,
    input  logic                            rst,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            data_valid,
    output logic                            data_ready,
    input  logic                            enable,
    output logic                            TXDATASB,
    output logic                            TXCKSB_en,
    output logic                            busy,
    output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_level
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = $clog2(FIFO_DEPTH + 1);
    localparam int BW = $clog2(DATA_W + 1);
    localparam int GW = GAP_CYCLES > 0 ? $clog2(GAP_CYCLES + 1) : 1;
    typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;
    state_t            r_state, w_state_n;
    logic [DATA_W-1:0] r_mem [FIFO_DEPTH];
    logic [AW-1:0]     r_wptr, r_rptr;
    logic [LW-1:0]     r_count;
    logic [DATA_W-1:0] r_sr;
    logic [DATA_W-1:0] w_head;
    logic [BW-1:0]     r_bit_cnt;
    logic [GW-1:0]     r_gap_cnt;
    logic              r_txd, r_txen;
    logic              w_push, w_load, w_shift, w_gap_start;
    logic              w_can_load, w_last_bit, w_gap_done, w_first, w_next_bit;
    assign w_head     = r_mem[r_rptr];
    assign data_ready = r_count != LW'(FIFO_DEPTH);
    assign w_push     = data_valid && data_ready;
    assign w_can_load = enable && r_count != '0;
    assign w_last_bit = r_bit_cnt == BW'(DATA_W);
    assign w_gap_done = r_gap_cnt == GW'(GAP_CYCLES);
    assign w_first    = MSB_FIRST ? w_head[DATA_W-1] : w_head[0];
    assign w_next_bit = MSB_FIRST ? r_sr[DATA_W-1] : r_sr[0];
    assign TXDATASB   = r_txd;
    assign TXCKSB_en  = r_txen;
    assign busy       = r_state != IDLE;
    assign fifo_level = r_count;
    always_ff @(posedge pll_clk) begin
        if (rst) begin
            r_state   <= IDLE;
            r_wptr    <= '0;
            r_rptr    <= '0;
            r_count   <= '0;
            r_sr      <= '0;
            r_bit_cnt <= '0;
            r_gap_cnt <= '0;
            r_txd     <= 1'b0;
            r_txen    <= 1'b0;
        end else begin
            r_state <= w_state_n;
            if (w_push) begin
                r_mem[r_wptr] <= data_in;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_load) r_rptr <= r_rptr + 1'b1;
            r_count   <= r_count + LW'(w_push) - LW'(w_load);
            // the first bit goes straight to the pad, so the shift register holds only the remainder
            r_sr      <= w_load ? (MSB_FIRST ? w_head << 1 : w_head >> 1) : (MSB_FIRST ? r_sr << 1 : r_sr >> 1);
            r_bit_cnt <= w_load ? BW'(1) : r_bit_cnt + BW'(w_shift);
            r_gap_cnt <= w_gap_start ? GW'(1) : r_gap_cnt + GW'(r_state == GAP);
            r_txd     <= w_load ? w_first : (w_shift & w_next_bit);
            r_txen    <= w_load | w_shift;
        end
    end
    always_comb begin
        w_state_n   = r_state;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        w_gap_start = 1'b0;
        case (r_state)
            IDLE: begin
                w_load    = w_can_load;
                w_state_n = w_can_load ? SHIFT : IDLE;
            end
            SHIFT: begin
                if (!w_last_bit) begin
                    w_shift = 1'b1;
                end else if (GAP_CYCLES > 0) begin
                    w_gap_start = 1'b1;
                    w_state_n   = GAP;
                end else begin
                    // zero dead time: chain straight into the next packet
                    w_load    = w_can_load;
                    w_state_n = w_can_load ? SHIFT : IDLE;
                end
            end
            GAP: begin
                if (w_gap_done) begin
                    w_load    = w_can_load;
                    w_state_n = w_can_load ? SHIFT : IDLE;
                end
            end
            default: w_state_n = IDLE;
        endcase
    end
endmodule

// File: tb/tb_sb_tx_serializer_pkt.sv
// tb_sb_tx_serializer_pkt: self-checking bench for sb_tx_serializer_pkt (default build plus 16-bit/no-gap/MSB-first build)
module tb_sb_tx_serializer_pkt;
    logic        pll_clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] data_a = '0;
    logic        valid_a = 1'b0, enable_a = 1'b0;
    logic        ready_a, txd_a, en_a, busy_a;
    logic [2:0]  lvl_a;
    logic [15:0] data_b = '0;
    logic        valid_b = 1'b0, enable_b = 1'b0;
    logic        ready_b, txd_b, en_b, busy_b;
    logic [2:0]  lvl_b;
    logic [6:0]  obs_a;
    int          checks = 0, errors = 0;
    logic [63:0] mq[$];
    logic [63:0] mcur = '0;
    int          mpos = 0;

    always #5 pll_clk = ~pll_clk;

    sb_tx_serializer_pkt dut_a (
        .pll_clk(pll_clk), .rst(rst), .data_in(data_a), .data_valid(valid_a), .data_ready(ready_a),
        .enable(enable_a), .TXDATASB(txd_a), .TXCKSB_en(en_a), .busy(busy_a), .fifo_level(lvl_a)
    );

    sb_tx_serializer_pkt #(.DATA_W(16), .FIFO_DEPTH(4), .GAP_CYCLES(0), .MSB_FIRST(1'b1)) dut_b (
        .pll_clk(pll_clk), .rst(rst), .data_in(data_b), .data_valid(valid_b), .data_ready(ready_b),
        .enable(enable_b), .TXDATASB(txd_b), .TXCKSB_en(en_b), .busy(busy_b), .fifo_level(lvl_b)
    );

    assign obs_a = {txd_a, en_a, busy_a, lvl_a, ready_a};

    // Reference for the default build: a packet queue plus the position within the
    // DATA_W + GAP_CYCLES = 96 cycle transmit window (0 = idle, 1..64 data, 65..96 dead time).
    task automatic step();
        bit can, psh;
        @(posedge pll_clk);
        if (rst) begin
            mq.delete();
            mpos = 0;
        end else begin
            can = enable_a && mq.size() != 0;
            psh = valid_a && mq.size() < 4;
            if (mpos == 0 || mpos == 96) begin
                if (can) begin
                    mcur = mq.pop_front();
                    mpos = 1;
                end else mpos = 0;
            end else mpos++;
            if (psh) mq.push_back(data_a);
        end
        #1;
    endtask

    function automatic logic [6:0] exp_a();
        bit on = mpos >= 1 && mpos <= 64;
        bit b  = on ? mcur[(mpos - 1) & 63] : 1'b0;
        return {b, on, mpos != 0, 3'(mq.size()), mq.size() < 4};
    endfunction

    task automatic do_reset();
        rst = 1'b1; valid_a = 1'b0; enable_a = 1'b0; valid_b = 1'b0; enable_b = 1'b0;
        step(); step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs_a !== 7'b0000001) begin
            errors++; $display("FAIL reset_a: got %b required %b", obs_a, 7'b0000001);
        end
        checks++;
        if ({txd_b, en_b, busy_b, lvl_b, ready_b} !== 7'b0000001) begin
            errors++; $display("FAIL reset_b: got %b required %b", {txd_b, en_b, busy_b, lvl_b, ready_b}, 7'b0000001);
        end
    endtask

    task automatic test_single();
        int n_en = 0;
        do_reset();
        enable_a = 1'b1; valid_a = 1'b1; data_a = 64'hA5A5A5A5A5A5A5A5;
        step();
        valid_a = 1'b0;
        for (int t = 0; t < 100; t++) begin
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL single t=%0d: got %b required %b", t, obs_a, exp_a());
            end
            n_en += int'(en_a);
            step();
        end
        checks++;
        if (n_en != 64) begin
            errors++; $display("FAIL single_en_len: got %0d required 64", n_en);
        end
        checks++;
        if (busy_a !== 1'b0) begin
            errors++; $display("FAIL single_idle: busy got %b required 0", busy_a);
        end
    endtask

    task automatic test_back_to_back();
        int t1 = -1, t2 = -1, off = -1;
        logic pe = 1'b0;
        do_reset();
        enable_a = 1'b1; valid_a = 1'b1; data_a = 64'h1;
        step();
        data_a = 64'h8000_0000_0000_0000;
        step();
        valid_a = 1'b0;
        for (int t = 0; t < 230; t++) begin
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL b2b t=%0d: got %b required %b", t, obs_a, exp_a());
            end
            if (en_a && !pe) begin
                if (t1 < 0) t1 = t; else if (t2 < 0) t2 = t;
            end
            if (t2 >= 0 && en_a && txd_a && off < 0) off = t - t2;
            pe = en_a;
            step();
        end
        checks++;
        if (t2 - t1 != 96) begin
            errors++; $display("FAIL b2b_spacing: got %0d required 96", t2 - t1);
        end
        checks++;
        if (off != 63) begin
            errors++; $display("FAIL b2b_one_pos: got %0d required 63", off);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] sent[$];
        logic [63:0] rx[$];
        logic [63:0] cur = '0;
        int nb = 0;
        do_reset();
        valid_a = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_a = {$urandom, $urandom};
            sent.push_back(data_a);
            step();
        end
        valid_a = 1'b0;
        checks++;
        if ({lvl_a, ready_a} !== 4'b1000) begin
            errors++; $display("FAIL bp_full: level/ready got %b required 1000", {lvl_a, ready_a});
        end
        enable_a = 1'b1;
        for (int t = 0; t < 4 * 96 + 20; t++) begin
            step();
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL bp t=%0d: got %b required %b", t, obs_a, exp_a());
            end
            if (en_a) begin
                cur[nb] = txd_a;
                nb++;
                if (nb == 64) begin
                    rx.push_back(cur);
                    nb = 0;
                end
            end
        end
        checks++;
        if (rx.size() != 4) begin
            errors++; $display("FAIL bp_count: got %0d required 4", rx.size());
        end
        for (int i = 0; i < 4 && i < rx.size(); i++) begin
            checks++;
            if (rx[i] !== sent[i]) begin
                errors++; $display("FAIL bp_pkt%0d: got %h required %h", i, rx[i], sent[i]);
            end
        end
    endtask

    task automatic test_enable_drop();
        do_reset();
        enable_a = 1'b1; valid_a = 1'b1; data_a = {$urandom, $urandom};
        step();
        data_a = {$urandom, $urandom};
        step();
        valid_a = 1'b0;
        for (int t = 0; t < 10; t++) step();
        enable_a = 1'b0;
        for (int t = 0; t < 120; t++) begin
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL en_drop t=%0d: got %b required %b", t, obs_a, exp_a());
            end
            step();
        end
        checks++;
        if ({busy_a, lvl_a} !== 4'b0001) begin
            errors++; $display("FAIL en_drop_end: busy/level got %b required 0001", {busy_a, lvl_a});
        end
    endtask

    task automatic test_mid_reset();
        int n_en = 0;
        do_reset();
        enable_a = 1'b1; valid_a = 1'b1; data_a = 64'hFFFF_FFFF_FFFF_FFFF;
        step();
        data_a = 64'hFFFF_0000_FFFF_0000;
        step();
        valid_a = 1'b0;
        for (int t = 0; t < 19; t++) step();
        rst = 1'b1;
        step();
        checks++;
        if (obs_a !== 7'b0000001) begin
            errors++; $display("FAIL mid_reset: got %b required %b", obs_a, 7'b0000001);
        end
        rst = 1'b0;
        for (int t = 0; t < 100; t++) begin
            step();
            n_en += int'(en_a | txd_a | busy_a);
        end
        checks++;
        if (n_en != 0) begin
            errors++; $display("FAIL mid_reset_residual: got %0d active cycles required 0", n_en);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int t = 0; t < 1500; t++) begin
            valid_a  = ($urandom % 3) == 0;
            data_a   = {$urandom, $urandom};
            enable_a = (t % 400) < 300 ? ($urandom % 8) != 0 : 1'b0;
            step();
            checks++;
            if (obs_a !== exp_a()) begin
                errors++; $display("FAIL random t=%0d: got %b required %b", t, obs_a, exp_a());
            end
        end
    endtask

    task automatic test_msb16();
        logic [31:0] cap = '0;
        int n_en = 0, first = -1, last = -1;
        do_reset();
        valid_b = 1'b1; data_b = 16'hC001;
        step();
        data_b = 16'h0003;
        step();
        valid_b = 1'b0;
        checks++;
        if (lvl_b !== 3'd2) begin
            errors++; $display("FAIL msb16_level: got %0d required 2", lvl_b);
        end
        enable_b = 1'b1;
        for (int t = 0; t < 40; t++) begin
            step();
            if (en_b) begin
                cap = {cap[30:0], txd_b};
                n_en++;
                if (first < 0) first = t;
                last = t;
            end
        end
        checks++;
        if (cap !== 32'b1100000000000001_0000000000000011) begin
            errors++; $display("FAIL msb16_bits: got %b required %b", cap, 32'b1100000000000001_0000000000000011);
        end
        checks++;
        if (n_en != 32 || last - first != 31) begin
            errors++; $display("FAIL msb16_en: got %0d cycles span %0d required 32 span 31", n_en, last - first);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_backpressure();
        test_enable_drop();
        test_mid_reset();
        test_random();
        test_msb16();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/sb_tx_serializer_pkt.md
# sb_tx_serializer_pkt

Parametrised sideband transmit serializer: buffers DATA_W-bit sideband packets in an internal FIFO and shifts each one out on TXDATASB one bit per pll_clk. After every packet it inserts a mandatory dead time of GAP_CYCLES low cycles. It drives a clock-gate enable so the forwarded sideband clock toggles only during data bits. It sits between the sideband packet framer and the TX pad driver, replacing the fixed 64-bit, unbuffered serializer.

## Interface
- DATA_W, 64, packet width in bits (≥2)
- FIFO_DEPTH, 4, packets buffered (power of 2, ≥2)
- GAP_CYCLES, 32, low cycles inserted after each packet (0 = back-to-back)
- MSB_FIRST, 0, 0: bit 0 sent first; 1: bit DATA_W-1 sent first

- pll_clk  in  1  serial bit clock; sole clock
- rst  in  1  synchronous, active-high reset
- data_in  in  DATA_W  packet to enqueue
- data_valid  in  1  data_in valid
- data_ready  out  1  FIFO can accept; equals !full (combinational from FIFO count)
- enable  in  1  permits starting a new packet
- TXDATASB  out  1  serial data (registered)
- TXCKSB_en  out  1  clock-gate enable, high exactly during data bits (registered)
- busy  out  1  state ≠ IDLE
- fifo_level  out  $clog2(FIFO_DEPTH+1)  packets currently queued

## Operation
- Push: data_valid && data_ready at a rising edge writes data_in. Push while full is ignored; the FIFO and count are unchanged.
- FSM states:
  - IDLE → SHIFT when enable && fifo_level≠0. The load pops one word; TXDATASB is set to its first bit and the shift register to the remainder. bit_cnt = 1.
  - SHIFT: each edge outputs the next bit and increments bit_cnt. After bit DATA_W has been output, move to GAP if GAP_CYCLES>0.
  - SHIFT with GAP_CYCLES=0 acts like the end of GAP.
  - GAP: TXDATASB=0, TXCKSB_en=0, gap_cnt counts GAP_CYCLES cycles. At the end:
    - if enable && FIFO non-empty, load the next word directly (SHIFT);
    - otherwise go to IDLE.
- enable is sampled only when deciding whether to load. Deasserting enable never truncates a packet or a gap.
- Simultaneous push and pop: both happen and fifo_level is unchanged. When full, a pop frees a slot, but data_ready goes high only from the next cycle.
- Counters: bit_cnt is $clog2(DATA_W+1) bits and gap_cnt is $clog2(GAP_CYCLES+1) bits; both saturate-free, reset on state entry.
- Reset, including mid-packet: state=IDLE, FIFO flushed (fifo_level=0), TXDATASB=0, TXCKSB_en=0, busy=0, data_ready=1. The partial packet is discarded.

## Timing
- Push at edge E into an empty FIFO while IDLE with enable=1: load at edge E+1. Bit 0 (or bit DATA_W-1) is valid on TXDATASB from E+1, and the last bit in the cycle after edge E+DATA_W.
- TXCKSB_en is high for exactly DATA_W consecutive cycles per packet, aligned with TXDATASB bits.
- Gap occupies edges E+DATA_W+1 … E+DATA_W+GAP_CYCLES. The next packet's first bit comes at edge E+1+DATA_W+GAP_CYCLES if it was queued.
- Sustained throughput: one packet per DATA_W+GAP_CYCLES cycles.
- fifo_level and data_ready update at the edge of the push/pop. busy is high from the load edge through the last gap cycle.

## Test plan
- Single packet, defaults: push 64'hA5A5A5A5A5A5A5A5 with enable=1. TXDATASB = 1,0,1,0,0,1,0,1… LSB-first for 64 cycles with TXCKSB_en=1, then 32 cycles of 0/0, then busy=0.
- Back-to-back: push 64'h0000_0000_0000_0001 then 64'h8000_0000_0000_0000. The second packet's first bit starts exactly 96 cycles after the first's, and the single 1 of the second packet appears 63 cycles into its data window.
- Backpressure: enable=0, push 5 packets. The first 4 are accepted, fifo_level=4, data_ready=0, and the 5th is dropped. Raising enable transmits exactly 4 packets in order.
- enable dropped at bit 10 of a packet: the full 64 bits and 32 gap cycles still complete, then IDLE with fifo_level unchanged.
- rst asserted at bit 20: on the next edge TXDATASB=0, TXCKSB_en=0, busy=0, fifo_level=0, data_ready=1, and no residual bits after reset release.
- DATA_W=16, GAP_CYCLES=0, MSB_FIRST=1: push 16'hC001, 16'h0003. Output is 1100000000000001 0000000000000011 with no gap, and TXCKSB_en is high for 32 continuous cycles.
